ssd_sequence_checker: RTL and testbench
=======================================

Name: ssd_sequence_checker

Overview:
- Drives the seven-segment sequence-entry module: generates the 16-bit target sequence and the display-mode code that starts it.
- Collects the player's four committed symbols (4-bit one-hot-low value plus the "next" button) and compares them against the target.
- Reports solved or strike to the game controller.
- Sits between the top-level game FSM and the seven-segment sequence display/entry block.

Parameters:
- SEED, 16'hACE1, LFSR reset value (must be nonzero).
- SHOW_SECS, 2, one_sec pulses during which the target is shown before entry opens.
- MAX_STRIKES, 3, strike count that asserts exploded.
- MODE_CODE, 8'h10, display code that starts the display/entry block.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse from game FSM: arm a new round
- one_sec  in  1  one-cycle pulse per second
- button_next  in  1  debounced level of the "next" button (commit)
- entry_in  in  4  player's current symbol from the entry block
- sequence_gen  out  16  target sequence, nibble 0 = digit 1
- display  out  8  mode code to the entry block
- busy  out  1  round in progress
- solved  out  1  one-cycle pulse: all four digits matched
- strike  out  1  one-cycle pulse: at least one digit mismatched
- strike_count  out  2  accumulated strikes, saturating
- exploded  out  1  level; strike_count == MAX_STRIKES

Behaviour:
- Symbol encoding: 4'b1110, 4'b1101, 4'b1011, 4'b0111; symbol(sel) = ~(4'b0001 << sel), sel in 0..3.
- LFSR:
  - 16-bit Galois, mask 16'hB400, free-running every clk.
  - Reset value SEED.
  - Never loads zero.
- Commit detect: register button_next. commit = button_next & ~button_next_q, i.e. the cycle after the rising edge is seen.
- Reset values:
  - sequence_gen = 16'hEEEE.
  - display = 8'h00.
  - busy = solved = strike = exploded = 0.
  - strike_count = 0.
  - State = IDLE, digit index = 0, mismatch flag = 0, second counter = 0.
- IDLE:
  - display = 0.
  - On start with exploded = 0: latch sequence_gen from LFSR bits [1:0],[3:2],[5:4],[7:6] for nibbles 0..3. Then go to SHOW.
  - start is ignored while exploded = 1.
- SHOW:
  - display = MODE_CODE, busy = 1.
  - Count one_sec pulses. When the count reaches SHOW_SECS, go to ENTRY next cycle and clear the counter.
  - Commits in SHOW are ignored.
- ENTRY:
  - display = MODE_CODE, busy = 1.
  - On commit: compare entry_in with sequence_gen nibble[index]; on inequality set the mismatch flag; index += 1.
  - On the commit with index == 3, go to JUDGE.
  - entry_in values that are not legal symbols count as mismatches.
- JUDGE (exactly one cycle):
  - display = 0.
  - If mismatch = 0, pulse solved.
  - Otherwise pulse strike and increment strike_count, saturating at MAX_STRIKES.
  - exploded asserts the same cycle strike_count reaches MAX_STRIKES.
  - Clear index and mismatch flag, then go to IDLE.
- start while busy is ignored; sequence_gen is stable for the whole round.
- button_next held high counts as one commit only.
- display drops to 0 in JUDGE so the entry block does not re-trigger from its init state.
- Reset asserted mid-round returns every output to its reset value immediately (asynchronous), including strike_count.
- solved and strike are mutually exclusive and never asserted outside JUDGE.

Decomposition:
- Shared package holds:
  - Symbol constants SYM_0..SYM_3.
  - MODE_CODE.
  - FSM state enum (IDLE, SHOW, ENTRY, JUDGE).
  - LFSR mask.
- One natural sub-module: seq_lfsr16 (SEED parameter; clk, reset, q[15:0]).
- Edge detect and FSM live in the top.

Test Plan:
- Reset, then start with LFSR bits[7:0] = 8'b00_01_10_11 -> sequence_gen = 16'hEDB7 (nibble0 = 7, nibble1 = B, nibble2 = D, nibble3 = E). display = 8'h10 and busy = 1 the cycle after start.
- In SHOW, 2 one_sec pulses plus 5 commits -> commits ignored; ENTRY is entered only after the second pulse and index is still 0.
- In ENTRY, commit 7, B, D, E in order -> solved pulses for exactly 1 cycle, strike = 0, display = 0, busy = 0, strike_count = 0.
- Commit 7, B, 4'b1111, E -> strike pulses for 1 cycle and strike_count = 1. Three such rounds -> exploded = 1, and a subsequent start is ignored.
- Hold button_next high for 50 cycles in ENTRY -> exactly one digit consumed (index 0 -> 1).
- Assert reset after the second commit -> all outputs at reset values in the same cycle; after release, start begins a fresh round with index 0.

Source files
------------

// File: rtl/ssd_sequence_checker_pkg.sv
// Shared definitions for the seven-segment sequence checker: symbol codes,
// display mode code, FSM states and the LFSR feedback mask.
package ssd_sequence_checker_pkg;

    localparam logic [3:0] SYM_0 = 4'b1110;
    localparam logic [3:0] SYM_1 = 4'b1101;
    localparam logic [3:0] SYM_2 = 4'b1011;
    localparam logic [3:0] SYM_3 = 4'b0111;

    localparam logic [7:0]  DEF_MODE_CODE = 8'h10;
    localparam logic [15:0] LFSR_MASK     = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        ENTRY,
        JUDGE
    } state_t;

    // One-hot-low symbol for a 2-bit selector.
    function automatic logic [3:0] symbol(input logic [1:0] sel);
        logic [3:0] sym;
        case (sel)
            2'd0:    sym = SYM_0;
            2'd1:    sym = SYM_1;
            2'd2:    sym = SYM_2;
            default: sym = SYM_3;
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/seq_lfsr16.sv
// Free-running 16-bit Galois LFSR (right-shifting) used as the round
// sequence source.
module seq_lfsr16
    import ssd_sequence_checker_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    logic [15:0] q_next;

    always_comb begin
        q_next = {1'b0, q[15:1]} ^ (q[0] ? LFSR_MASK : 16'h0000);
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= SEED;
        end else if (q_next == 16'h0000) begin
            q <= SEED;  // lock-up guard: never hold the all-zero state
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/ssd_sequence_checker.sv
// Generates a four-symbol target, shows it for SHOW_SECS seconds, collects
// four committed symbols and reports solved or strike to the game FSM.
module ssd_sequence_checker
    import ssd_sequence_checker_pkg::*;
#(
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          SHOW_SECS   = 2,
    parameter int          MAX_STRIKES = 3,
    parameter logic [7:0]  MODE_CODE   = DEF_MODE_CODE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        one_sec,
    input  logic        button_next,
    input  logic [3:0]  entry_in,
    output logic [15:0] sequence_gen,
    output logic [7:0]  display,
    output logic        busy,
    output logic        solved,
    output logic        strike,
    output logic [1:0]  strike_count,
    output logic        exploded
);

    localparam int SW = (SHOW_SECS > 1) ? $clog2(SHOW_SECS) : 1;

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic            mismatch_q, mismatch_d;
    logic [SW-1:0]   sec_cnt_q, sec_cnt_d;
    logic [15:0]     seq_q, seq_d;
    logic [1:0]      strikes_q, strikes_d;
    logic            btn_q;
    logic            commit;
    logic [3:0]      cur_digit;
    logic [15:0]     lfsr_q;
    logic            unused_lfsr_hi;

    seq_lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    // Only the low byte selects symbols; the upper bits just feed the shift.
    assign unused_lfsr_hi = ^lfsr_q[15:8];

    assign commit       = button_next & ~btn_q;
    assign cur_digit    = seq_q[{idx_q, 2'b00} +: 4];
    assign sequence_gen = seq_q;
    assign strike_count = strikes_q;
    assign exploded     = (strikes_q == 2'(MAX_STRIKES));

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mismatch_d = mismatch_q;
        sec_cnt_d  = sec_cnt_q;
        seq_d      = seq_q;
        strikes_d  = strikes_q;
        display    = 8'h00;
        busy       = 1'b0;
        solved     = 1'b0;
        strike     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !exploded) begin
                    seq_d      = {symbol(lfsr_q[7:6]), symbol(lfsr_q[5:4]),
                                  symbol(lfsr_q[3:2]), symbol(lfsr_q[1:0])};
                    idx_d      = 2'd0;
                    mismatch_d = 1'b0;
                    sec_cnt_d  = '0;
                    state_d    = SHOW;
                end
            end

            SHOW: begin
                display = MODE_CODE;
                busy    = 1'b1;
                if (one_sec) begin
                    if (sec_cnt_q == SW'(SHOW_SECS - 1)) begin
                        sec_cnt_d = '0;
                        state_d   = ENTRY;
                    end else begin
                        sec_cnt_d = sec_cnt_q + 1'b1;
                    end
                end
            end

            ENTRY: begin
                display = MODE_CODE;
                busy    = 1'b1;
                if (commit) begin
                    // Targets are always legal symbols, so illegal input mismatches.
                    if (entry_in != cur_digit) begin
                        mismatch_d = 1'b1;
                    end
                    idx_d = idx_q + 1'b1;
                    if (idx_q == 2'd3) begin
                        state_d = JUDGE;
                    end
                end
            end

            JUDGE: begin
                solved = ~mismatch_q;
                strike = mismatch_q;
                if (mismatch_q && (strikes_q != 2'(MAX_STRIKES))) begin
                    strikes_d = strikes_q + 1'b1;
                end
                idx_d      = 2'd0;
                mismatch_d = 1'b0;
                state_d    = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            mismatch_q <= 1'b0;
            sec_cnt_q  <= '0;
            seq_q      <= 16'hEEEE;
            strikes_q  <= 2'd0;
            btn_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mismatch_q <= mismatch_d;
            sec_cnt_q  <= sec_cnt_d;
            seq_q      <= seq_d;
            strikes_q  <= strikes_d;
            btn_q      <= button_next;
        end
    end

endmodule

// File: tb/tb_ssd_sequence_checker.sv
// Directed bench for ssd_sequence_checker: rounds are started when the
// bench's own LFSR model shows low byte 8'h1B, so the target is 16'hEDB7.
module tb_ssd_sequence_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        one_sec = 1'b0;
    logic        button_next = 1'b0;
    logic [3:0]  entry_in = 4'b1110;
    logic [15:0] sequence_gen;
    logic [7:0]  display;
    logic        busy;
    logic        solved;
    logic        strike;
    logic [1:0]  strike_count;
    logic        exploded;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] model;

    ssd_sequence_checker dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .one_sec      (one_sec),
        .button_next  (button_next),
        .entry_in     (entry_in),
        .sequence_gen (sequence_gen),
        .display      (display),
        .busy         (busy),
        .solved       (solved),
        .strike       (strike),
        .strike_count (strike_count),
        .exploded     (exploded)
    );

    always #5 clk = ~clk;

    // Reference Galois LFSR, x^16+x^14+x^13+x^11+1, seed ACE1.
    always @(posedge clk or posedge reset) begin
        if (reset) model <= 16'hACE1;
        else       model <= {1'b0, model[15:1]} ^ (model[0] ? 16'hB400 : 16'h0000);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_sec();
        one_sec = 1'b1;
        tick();
        one_sec = 1'b0;
    endtask

    task automatic commit(input logic [3:0] sym);
        button_next = 1'b0;
        tick();
        entry_in    = sym;
        button_next = 1'b1;
        tick();
        button_next = 1'b0;
    endtask

    task automatic start_round();
        int k;
        k = 0;
        while (model[7:0] != 8'h1B && k < 70000) begin
            tick();
            k++;
        end
        if (k >= 70000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL start_wait: lfsr low byte 1B not seen within %0d cycles", k);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({sequence_gen, display, busy, solved, strike, strike_count, exploded} !==
            {16'hEEEE, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_values: got seq=%h disp=%h busy=%b sol=%b str=%b cnt=%0d exp=%b want seq=eeee disp=00 rest 0",
                     sequence_gen, display, busy, solved, strike, strike_count, exploded);
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_start();
        start_round();
        @(negedge clk);
        n_cmp++;
        if (sequence_gen !== 16'hEDB7) begin
            n_bad++;
            $display("FAIL start_sequence: got %h want edb7", sequence_gen);
        end
        n_cmp++;
        if ({display, busy} !== {8'h10, 1'b1}) begin
            n_bad++;
            $display("FAIL start_display: got disp=%h busy=%b want disp=10 busy=1", display, busy);
        end
        // A second start during the round must not reload the target.
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({sequence_gen, busy} !== {16'hEDB7, 1'b1}) begin
            n_bad++;
            $display("FAIL start_while_busy: got seq=%h busy=%b want seq=edb7 busy=1", sequence_gen, busy);
        end
    endtask

    task automatic test_show_ignore();
        commit(4'b1111);
        commit(4'b1111);
        pulse_sec();
        @(negedge clk);
        n_cmp++;
        if ({display, busy} !== {8'h10, 1'b1}) begin
            n_bad++;
            $display("FAIL show_after_1s: got disp=%h busy=%b want disp=10 busy=1", display, busy);
        end
        commit(4'b1111);
        commit(4'b1111);
        commit(4'b1111);
        pulse_sec();
        commit(4'h7);
        commit(4'hB);
        commit(4'hD);
        @(negedge clk);
        n_cmp++;
        if ({busy, solved, strike} !== 3'b100) begin
            n_bad++;
            $display("FAIL entry_three_digits: got busy=%b sol=%b str=%b want 1 0 0", busy, solved, strike);
        end
        commit(4'hE);
        @(negedge clk);
        n_cmp++;
        if ({solved, strike, display, busy} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            n_bad++;
            $display("FAIL judge_solved: got sol=%b str=%b disp=%h busy=%b want 1 0 00 0",
                     solved, strike, display, busy);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({solved, strike, strike_count, busy, sequence_gen} !== {1'b0, 1'b0, 2'd0, 1'b0, 16'hEDB7}) begin
            n_bad++;
            $display("FAIL after_solved: got sol=%b str=%b cnt=%0d busy=%b seq=%h want 0 0 0 0 edb7",
                     solved, strike, strike_count, busy, sequence_gen);
        end
    endtask

    task automatic test_hold_button();
        start_round();
        pulse_sec();
        pulse_sec();
        entry_in    = 4'h7;
        button_next = 1'b1;
        repeat (50) tick();
        button_next = 1'b0;
        commit(4'hB);
        commit(4'hD);
        @(negedge clk);
        n_cmp++;
        if ({busy, strike} !== 2'b10) begin
            n_bad++;
            $display("FAIL hold_index: got busy=%b str=%b want busy=1 str=0", busy, strike);
        end
        commit(4'hE);
        @(negedge clk);
        n_cmp++;
        if ({solved, strike} !== 2'b10) begin
            n_bad++;
            $display("FAIL hold_solved: got sol=%b str=%b want 1 0", solved, strike);
        end
    endtask

    task automatic test_strikes();
        for (int i = 1; i <= 3; i++) begin
            start_round();
            pulse_sec();
            pulse_sec();
            commit(4'h7);
            commit(4'hB);
            commit(4'hF);
            commit(4'hE);
            @(negedge clk);
            n_cmp++;
            if ({strike, solved, display} !== {1'b1, 1'b0, 8'h00}) begin
                n_bad++;
                $display("FAIL strike_pulse_%0d: got str=%b sol=%b disp=%h want 1 0 00", i, strike, solved, display);
            end
            tick();
            @(negedge clk);
            n_cmp++;
            if ({strike, strike_count, exploded} !== {1'b0, 2'(i), (i == 3)}) begin
                n_bad++;
                $display("FAIL strike_count_%0d: got str=%b cnt=%0d exp=%b want str=0 cnt=%0d exp=%b",
                         i, strike, strike_count, exploded, i, (i == 3));
            end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, display, strike_count, exploded} !== {1'b0, 8'h00, 2'd3, 1'b1}) begin
            n_bad++;
            $display("FAIL start_when_exploded: got busy=%b disp=%h cnt=%0d exp=%b want 0 00 3 1",
                     busy, display, strike_count, exploded);
        end
    endtask

    task automatic test_reset_mid_round();
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({strike_count, exploded} !== {2'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_clears_exploded: got cnt=%0d exp=%b want 0 0", strike_count, exploded);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        start_round();
        pulse_sec();
        pulse_sec();
        commit(4'h7);
        commit(4'hB);
        commit(4'hF);
        commit(4'hE);
        tick();
        @(negedge clk);
        n_cmp++;
        if (strike_count !== 2'd1) begin
            n_bad++;
            $display("FAIL pre_reset_strike: got cnt=%0d want 1", strike_count);
        end
        start_round();
        pulse_sec();
        pulse_sec();
        commit(4'h7);
        commit(4'hB);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({sequence_gen, display, busy, solved, strike, strike_count, exploded} !==
            {16'hEEEE, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL async_reset: got seq=%h disp=%h busy=%b sol=%b str=%b cnt=%0d exp=%b want seq=eeee disp=00 rest 0",
                     sequence_gen, display, busy, solved, strike, strike_count, exploded);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        start_round();
        @(negedge clk);
        n_cmp++;
        if ({sequence_gen, busy} !== {16'hEDB7, 1'b1}) begin
            n_bad++;
            $display("FAIL fresh_round_start: got seq=%h busy=%b want edb7 1", sequence_gen, busy);
        end
        pulse_sec();
        pulse_sec();
        commit(4'h7);
        commit(4'hB);
        commit(4'hD);
        commit(4'hE);
        @(negedge clk);
        n_cmp++;
        if ({solved, strike, strike_count} !== {1'b1, 1'b0, 2'd0}) begin
            n_bad++;
            $display("FAIL fresh_round_solved: got sol=%b str=%b cnt=%0d want 1 0 0", solved, strike, strike_count);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_show_ignore();
        test_hold_button();
        test_strikes();
        test_reset_mid_round();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
